// File: rtl/dec_fpr_pkg.sv
// Shared types and default sizes for the multi-bank FPR file and its bank-switch engine.
package dec_fpr_pkg;

    localparam int FPR_FLEN = 32;
    localparam int FPR_NREG = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } fpr_sw_state_e;

endpackage

// File: rtl/dec_fpr_copy_fsm.sv
// Bank-switch sequencer: latches the target bank, walks the copy index and
// signals the cycle on which the active bank changes.
module dec_fpr_copy_fsm
    import dec_fpr_pkg::*;
#(
    parameter int NREG   = FPR_NREG,
    parameter int NBANKS = 2,
    localparam int AW    = $clog2(NREG),
    localparam int BW    = $clog2(NBANKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sw_req,
    input  logic [BW-1:0] sw_bank,
    input  logic          sw_copy,
    input  logic [BW-1:0] act_bank,
    output logic          sw_busy,
    output logic          sw_done,
    output logic          copy_we,
    output logic [AW-1:0] copy_idx,
    output logic [BW-1:0] tgt_bank,
    output logic          switch_now
);

    fpr_sw_state_e state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [BW-1:0] tgt_q, tgt_d;

    // NOTE: every output and next-state value gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tgt_d      = tgt_q;
        copy_we    = 1'b0;
        switch_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sw_req) begin
                    tgt_d = sw_bank;
                    if (sw_copy && (sw_bank != act_bank)) begin
                        idx_d   = '0;
                        state_d = COPY;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            COPY: begin
                copy_we = 1'b1;
                idx_d   = idx_q + AW'(1);
                if (idx_q == AW'(NREG - 1)) state_d = DONE;
            end
            DONE: begin
                switch_now = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
        end
    end

    assign sw_busy  = (state_q == COPY);
    assign sw_done  = (state_q == DONE);
    assign copy_idx = idx_q;
    assign tgt_bank = tgt_q;

endmodule

// File: rtl/dec_fpr_bank_ctl.sv
// Multi-bank floating-point register file with copy-then-switch bank engine and FS dirty flag.
// Optional: RV_FPR_BYPASS_EN (same-cycle write-to-read forwarding), ASSERT_ON (protocol checks).
module dec_fpr_bank_ctl
    import dec_fpr_pkg::*;
#(
    parameter int FLEN   = FPR_FLEN,
    parameter int NREG   = FPR_NREG,
    parameter int NRD    = 4,
    parameter int NWR    = 3,
    parameter int NBANKS = 2,
    localparam int AW    = $clog2(NREG),
    localparam int BW    = $clog2(NBANKS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0]           rden,
    input  logic [NRD-1:0][AW-1:0]   raddr,
    output logic [NRD-1:0][FLEN-1:0] rd,
    input  logic [NWR-1:0]           wen,
    input  logic [NWR-1:0][AW-1:0]   waddr,
    input  logic [NWR-1:0][FLEN-1:0] wd,
    input  logic                     sw_req,
    input  logic [BW-1:0]            sw_bank,
    input  logic                     sw_copy,
    output logic                     sw_busy,
    output logic                     sw_done,
    output logic [BW-1:0]            act_bank,
    output logic                     fs_dirty,
    input  logic                     fs_clr
);

    logic [FLEN-1:0] mem_q  [NBANKS][NREG];
    logic [FLEN-1:0] mem_d  [NBANKS][NREG];
    logic            mem_en [NBANKS][NREG];
    logic [BW-1:0]   act_bank_q, act_bank_d;
    logic            fs_dirty_q, fs_dirty_d;
    logic            copy_we, switch_now;
    logic [AW-1:0]   copy_idx;
    logic [BW-1:0]   tgt_bank;

    dec_fpr_copy_fsm #(.NREG(NREG), .NBANKS(NBANKS)) u_copy_fsm (
        .clk        (clk),
        .rst        (rst),
        .sw_req     (sw_req),
        .sw_bank    (sw_bank),
        .sw_copy    (sw_copy),
        .act_bank   (act_bank_q),
        .sw_busy    (sw_busy),
        .sw_done    (sw_done),
        .copy_we    (copy_we),
        .copy_idx   (copy_idx),
        .tgt_bank   (tgt_bank),
        .switch_now (switch_now)
    );

    // Copy beat first, then ports in ascending order so the highest port (and any write) wins.
    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            for (int r = 0; r < NREG; r++) begin
                mem_en[b][r] = 1'b0;
                mem_d[b][r]  = '0;
                if (copy_we && (BW'(b) == tgt_bank) && (AW'(r) == copy_idx)) begin
                    mem_en[b][r] = 1'b1;
                    mem_d[b][r]  = mem_q[act_bank_q][r];
                end
                for (int p = 0; p < NWR; p++) begin
                    if (wen[p] && (waddr[p] == AW'(r)) &&
                        ((BW'(b) == act_bank_q) || (sw_busy && (BW'(b) == tgt_bank)))) begin
                        mem_en[b][r] = 1'b1;
                        mem_d[b][r]  = wd[p];
                    end
                end
            end
        end
    end

    // NOTE: storage is built from flops rather than a RAM macro, so every entry can be cleared by reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANKS; b++) begin
            for (int r = 0; r < NREG; r++) begin
                if (rst)                mem_q[b][r] <= '0;
                else if (mem_en[b][r])  mem_q[b][r] <= mem_d[b][r];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd[p] = mem_q[act_bank_q][raddr[p]];
`ifdef RV_FPR_BYPASS_EN
            for (int q = 0; q < NWR; q++) begin
                if (wen[q] && (waddr[q] == raddr[p])) rd[p] = wd[q];
            end
`endif
            if (!rden[p]) rd[p] = '0;
        end
    end

    always_comb begin
        act_bank_d = switch_now ? tgt_bank : act_bank_q;
        fs_dirty_d = fs_dirty_q;
        if (|wen)        fs_dirty_d = 1'b1;
        else if (fs_clr) fs_dirty_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_bank_q <= '0;
            fs_dirty_q <= 1'b0;
        end else begin
            act_bank_q <= act_bank_d;
            fs_dirty_q <= fs_dirty_d;
        end
    end

    assign act_bank = act_bank_q;
    assign fs_dirty = fs_dirty_q;

`ifdef ASSERT_ON
    logic multi_wr;
    always_comb begin
        multi_wr = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int q = p + 1; q < NWR; q++) begin
                if (wen[p] && wen[q] && (waddr[p] == waddr[q])) multi_wr = 1'b1;
            end
        end
    end

    a_no_req_busy: assert property (@(posedge clk) disable iff (rst) !(sw_req && sw_busy));
    a_multi_wr: assert property (@(posedge clk) disable iff (rst) !multi_wr)
        else $warning("same-cycle multi-port write to one FPR address");
`endif

endmodule

// File: tb/tb_dec_fpr_bank_ctl.sv
// Self-checking bench for dec_fpr_bank_ctl: directed vectors, switch sequences and a randomized phase
// checked against an array-level reference model.
module tb_dec_fpr_bank_ctl;

    localparam int FLEN = 32, NREG = 32, NRD = 4, NWR = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NRD-1:0]           rden;
    logic [NRD-1:0][4:0]      raddr;
    logic [NRD-1:0][FLEN-1:0] rd;
    logic [NWR-1:0]           wen;
    logic [NWR-1:0][4:0]      waddr;
    logic [NWR-1:0][FLEN-1:0] wd;
    logic                     sw_req, sw_bank, sw_copy, fs_clr;
    logic                     sw_busy, sw_done, act_bank, fs_dirty;

    int n_checks = 0;
    int n_errors = 0;

    dec_fpr_bank_ctl dut (
        .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rd(rd),
        .wen(wen), .waddr(waddr), .wd(wd),
        .sw_req(sw_req), .sw_bank(sw_bank), .sw_copy(sw_copy),
        .sw_busy(sw_busy), .sw_done(sw_done), .act_bank(act_bank),
        .fs_dirty(fs_dirty), .fs_clr(fs_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        rden = '0; raddr = '0; wen = '0; waddr = '0; wd = '0;
        sw_req = 1'b0; sw_bank = 1'b0; sw_copy = 1'b0; fs_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_port(input int p, input logic [4:0] a);
        rden[p]  = 1'b1;
        raddr[p] = a;
        #1;
    endtask

    // Reference model: whole banks as arrays; a copy completes as one bank snapshot when its
    // NREG busy cycles run out, since mirrored writes keep the target equal to the source.
    logic [31:0] m_mem [2][NREG];
    logic        m_act, m_tgt, m_dirty, m_done;
    int          m_busy;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NREG; r++) m_mem[b][r] = '0;
        m_act = 0; m_tgt = 0; m_dirty = 0; m_done = 0; m_busy = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wen[p]) m_mem[m_act][waddr[p]] = wd[p];
            if (|wen) m_dirty = 1;
            else if (fs_clr) m_dirty = 0;
            if (m_done) begin
                m_act  = m_tgt;
                m_done = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    for (int r = 0; r < NREG; r++) m_mem[m_tgt][r] = m_mem[m_act][r];
                    m_done = 1;
                end
            end else if (sw_req) begin
                m_tgt = sw_bank;
                if (sw_copy && (sw_bank != m_act)) m_busy = NREG;
                else m_done = 1;
            end
        end
    endtask

    function automatic logic [31:0] model_rd(input int p);
        logic [31:0] v;
        v = m_mem[m_act][raddr[p]];
`ifdef RV_FPR_BYPASS_EN
        for (int q = 0; q < NWR; q++)
            if (wen[q] && (waddr[q] == raddr[p])) v = wd[q];
`endif
        return rden[p] ? v : 32'h0;
    endfunction

    typedef struct {
        logic        ren;
        int          wp;
        logic [4:0]  addr;
        logic [31:0] data;
        int          rp;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0] exp_byp;
        bit          saw_done;

        tbl[0] = '{1'b1, 0, 5'd0,  32'hDEADBEEF, 0, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 1, 5'd31, 32'h12345678, 3, 32'h12345678};
        tbl[2] = '{1'b1, 2, 5'd16, 32'hFFFFFFFF, 1, 32'hFFFFFFFF};
        tbl[3] = '{1'b0, 0, 5'd9,  32'hCAFEF00D, 2, 32'h00000000};
        tbl[4] = '{1'b1, 1, 5'd9,  32'h0BADF00D, 2, 32'h0BADF00D};
        tbl[5] = '{1'b1, 2, 5'd3,  32'h0000000A, 0, 32'h0000000A};

        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        for (int p = 0; p < NRD; p++) read_port(p, 5'(p * 7));
        for (int p = 0; p < NRD; p++) check("reset_rd", rd[p], 32'h0);
        check("reset_act_bank", 32'(act_bank), 32'h0);
        check("reset_sw_busy", 32'(sw_busy), 32'h0);
        check("reset_sw_done", 32'(sw_done), 32'h0);
        check("reset_fs_dirty", 32'(fs_dirty), 32'h0);
        idle_inputs();

        // Write f5 via port 0, read via port 2 next cycle
        wen[0] = 1'b1; waddr[0] = 5'd5; wd[0] = 32'h3F800000;
        tick();
        idle_inputs();
        read_port(2, 5'd5);
        check("f5_rd2", rd[2], 32'h3F800000);
        check("f5_dirty", 32'(fs_dirty), 32'h1);
        idle_inputs();

        // Same-cycle writes to f7 from ports 0 and 2
        wen = 3'b101; waddr[0] = 5'd7; wd[0] = 32'h11; waddr[2] = 5'd7; wd[2] = 32'h22;
`ifdef RV_FPR_BYPASS_EN
        exp_byp = 32'h22;
`else
        exp_byp = 32'h0;
`endif
        read_port(1, 5'd7);
        check("f7_same_cycle", rd[1], exp_byp);
        tick();
        idle_inputs();
        read_port(1, 5'd7);
        check("f7_priority", rd[1], 32'h22);
        idle_inputs();

        // Table-driven write/read vectors
        for (int i = 0; i < 6; i++) begin
            wen[tbl[i].wp] = 1'b1; waddr[tbl[i].wp] = tbl[i].addr; wd[tbl[i].wp] = tbl[i].data;
            tick();
            idle_inputs();
            rden[tbl[i].rp] = tbl[i].ren; raddr[tbl[i].rp] = tbl[i].addr;
            #1;
            check($sformatf("vec%0d", i), rd[tbl[i].rp], tbl[i].exp);
            idle_inputs();
        end

        // Copy bank 0 into bank 1 and switch
        sw_req = 1'b1; sw_bank = 1'b1; sw_copy = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < NREG; i++) begin
            check("copy1_busy", 32'(sw_busy), 32'h1);
            check("copy1_no_done", 32'(sw_done), 32'h0);
            tick();
        end
        check("copy1_done", 32'(sw_done), 32'h1);
        check("copy1_busy_off", 32'(sw_busy), 32'h0);
        check("copy1_act_old", 32'(act_bank), 32'h0);
        tick();
        check("copy1_act_new", 32'(act_bank), 32'h1);
        check("copy1_done_pulse", 32'(sw_done), 32'h0);
        read_port(0, 5'd3); read_port(1, 5'd5); read_port(2, 5'd0); read_port(3, 5'd31);
        check("copy1_f3", rd[0], 32'h0000000A);
        check("copy1_f5", rd[1], 32'h3F800000);
        check("copy1_f0", rd[2], 32'hDEADBEEF);
        check("copy1_f31", rd[3], 32'h12345678);
        idle_inputs();

        // Copy bank 1 back into bank 0 with writes at idx=10 and an ignored second request
        sw_req = 1'b1; sw_bank = 1'b0; sw_copy = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) tick();
        check("copy2_busy_mid", 32'(sw_busy), 32'h1);
        wen = 3'b111;
        waddr[0] = 5'd0;  wd[0] = 32'h0000BEEF;
        waddr[1] = 5'd10; wd[1] = 32'h10101010;
        waddr[2] = 5'd20; wd[2] = 32'h20202020;
        sw_req = 1'b1; sw_bank = 1'b1; sw_copy = 1'b0;
        tick();
        idle_inputs();
        for (int i = 0; i < 21; i++) tick();
        check("copy2_done", 32'(sw_done), 32'h1);
        tick();
        check("copy2_act", 32'(act_bank), 32'h0);
        read_port(0, 5'd0); read_port(1, 5'd10); read_port(2, 5'd20); read_port(3, 5'd3);
        check("copy2_f0_mirror", rd[0], 32'h0000BEEF);
        check("copy2_f10_hit_idx", rd[1], 32'h10101010);
        check("copy2_f20", rd[2], 32'h20202020);
        check("copy2_f3", rd[3], 32'h0000000A);
        idle_inputs();
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (sw_done || sw_busy) saw_done = 1;
            tick();
        end
        check("copy2_req_ignored", 32'(saw_done), 32'h0);
        check("copy2_act_stays", 32'(act_bank), 32'h0);

        // Same-bank request completes next cycle with no copy
        sw_req = 1'b1; sw_bank = 1'b0; sw_copy = 1'b1;
        tick();
        idle_inputs();
        check("same_bank_done", 32'(sw_done), 32'h1);
        check("same_bank_busy", 32'(sw_busy), 32'h0);
        tick();
        check("same_bank_act", 32'(act_bank), 32'h0);

        // Reset during a copy at idx=12
        sw_req = 1'b1; sw_bank = 1'b1; sw_copy = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 12; i++) tick();
        check("abort_busy_before", 32'(sw_busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_act", 32'(act_bank), 32'h0);
        check("abort_busy", 32'(sw_busy), 32'h0);
        check("abort_done", 32'(sw_done), 32'h0);
        read_port(0, 5'd0); read_port(1, 5'd3); read_port(2, 5'd5); read_port(3, 5'd31);
        for (int p = 0; p < NRD; p++) check("abort_rd", rd[p], 32'h0);
        idle_inputs();
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (sw_done) saw_done = 1;
            tick();
        end
        check("abort_no_done", 32'(saw_done), 32'h0);

        // Switch without copy, then dirty-flag interplay
        sw_req = 1'b1; sw_bank = 1'b1; sw_copy = 1'b0;
        tick();
        idle_inputs();
        check("nocopy_done", 32'(sw_done), 32'h1);
        check("nocopy_busy", 32'(sw_busy), 32'h0);
        tick();
        check("nocopy_act", 32'(act_bank), 32'h1);
        saw_done = 0;
        for (int r = 0; r < NREG; r++) begin
            read_port(3, 5'(r));
            if (rd[3] !== 32'h0) saw_done = 1;
        end
        check("nocopy_all_zero", 32'(saw_done), 32'h0);
        idle_inputs();
        check("dirty_clear_before", 32'(fs_dirty), 32'h0);
        wen[1] = 1'b1; waddr[1] = 5'd1; wd[1] = 32'h5; fs_clr = 1'b1;
        tick();
        idle_inputs();
        check("dirty_clr_with_write", 32'(fs_dirty), 32'h1);
        fs_clr = 1'b1;
        tick();
        idle_inputs();
        check("dirty_cleared", 32'(fs_dirty), 32'h0);

        // Randomized phase against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(499) == 0);
            rden    = 4'($urandom);
            for (int p = 0; p < NRD; p++) raddr[p] = 5'($urandom_range(7));
            for (int p = 0; p < NWR; p++) begin
                wen[p]   = ($urandom_range(2) == 0);
                waddr[p] = 5'($urandom_range(7));
                wd[p]    = $urandom;
            end
            sw_req  = ($urandom_range(39) == 0);
            sw_bank = 1'($urandom);
            sw_copy = 1'($urandom);
            fs_clr  = ($urandom_range(9) == 0);
            @(negedge clk);
            for (int p = 0; p < NRD; p++) check($sformatf("rand_rd%0d", p), rd[p], model_rd(p));
            check("rand_busy", 32'(sw_busy), 32'(m_busy > 0));
            check("rand_done", 32'(sw_done), 32'(m_done));
            check("rand_act", 32'(act_bank), 32'(m_act));
            check("rand_dirty", 32'(fs_dirty), 32'(m_dirty));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
